seq_div_16bit: RTL and testbench
================================

Name: seq_div_16bit

Overview:
Multi-cycle signed 16-bit divider. It is the inverse counterpart of the team's single-cycle saturating CLA adder/subtractor: it undoes repeated addition by iterative restoring subtraction, one quotient bit per cycle. It sits beside the ALU as a start/done-handshaked functional unit. It applies the same saturation convention as the adder: clamp to 0x7FFF / 0x8000 and flag the event.

Parameters:
WIDTH, 16, operand/result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  signed two's-complement numerator, captured when start is accepted
divisor  input  WIDTH  signed two's-complement denominator, captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  signed quotient, saturated
remainder  output  WIDTH  signed remainder
Ovfl  output  1  saturation occurred (divide-by-zero or MIN/-1)
div_by_zero  output  1  divisor was zero

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy, done, Ovfl and div_by_zero are 0; quotient and remainder are 0; iteration counter is 0.
- Reset mid-operation aborts immediately. No done pulse follows. Outputs return to their reset values.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: on start=1, capture operands, record sign flags, load magnitude registers, counter=0, go to CALC.
  - CALC: one restoring step per cycle. Shift partial remainder left, bring in the next dividend magnitude bit, trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0. After WIDTH cycles, go to FIX.
  - FIX: apply signs, saturation and flags; write quotient, remainder, Ovfl and div_by_zero; go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency is fixed for every operand pair, including the special cases. If start is accepted at edge k, busy=1 from edge k+1 through edge k+WIDTH+1, and done=1 from edge k+WIDTH+2 to k+WIDTH+3. busy=0 while done=1.
- The start input is ignored in CALC, FIX and DONE. The operand inputs may change freely after acceptance.
- Back-to-back: start in the cycle after done (IDLE) is accepted.
- Magnitudes are computed at WIDTH+1 bits so that |0x8000| is representable.
- Sign rules:
  - The quotient truncates toward zero.
  - Quotient sign = dividend sign XOR divisor sign.
  - Remainder sign = dividend sign, and the remainder is 0 when exact.
- Special cases, resolved in FIX; the CALC cycles still elapse:
  - divisor=0: div_by_zero=1, Ovfl=1, remainder=dividend. quotient=0x7FFF if dividend>=0, else 0x8000.
  - dividend=0x8000 and divisor=0xFFFF: Ovfl=1, div_by_zero=0, quotient=0x7FFF, remainder=0.
  - Otherwise Ovfl=0 and div_by_zero=0.
- quotient, remainder, Ovfl and div_by_zero hold their values from FIX until the next FIX or reset. They are stable during the following operation's CALC.

Test Plan:
- 100 / 7: start 1 cycle -> done exactly WIDTH+2 edges later; quotient=0x000E, remainder=0x0002, Ovfl=0, div_by_zero=0.
- Signs: -100/7 -> 0xFFF2/0xFFFE; 100/-7 -> 0xFFF2/0x0002; -100/-7 -> 0x000E/0xFFFE; 0x8000/0x0001 -> 0x8000/0x0000, Ovfl=0.
- Divide by zero: 5/0 -> quotient=0x7FFF, remainder=0x0005, Ovfl=1, div_by_zero=1; -5/0 -> 0x8000, 0xFFFB, flags 1/1. Latency is identical to the normal case.
- MIN/-1: 0x8000/0xFFFF -> quotient=0x7FFF, remainder=0, Ovfl=1, div_by_zero=0. A following 7/2 -> 0x0003/0x0001 with both flags cleared.
- Handshake: pulse start again 3 cycles into CALC with different operands -> ignored; the first result is returned with a single done pulse. Start the cycle after done -> accepted; busy is high the next cycle.
- Reset: drop rst_n for 1 cycle at mid-CALC (asynchronous, not clock-aligned) -> busy, done and all results are 0 immediately; no done pulse follows. A new start then completes correctly with 1000/10 -> 0x0064/0.

Source files
------------

// File: rtl/seq_div_16bit_if.sv
// seq_div_16bit_if: start/done handshake and operand/result bundle for the sequential divider
interface seq_div_16bit_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             Ovfl;
  logic             div_by_zero;
  modport master(output start, dividend, divisor,
                 input busy, done, quotient, remainder, Ovfl, div_by_zero);
  modport slave(input start, dividend, divisor,
                output busy, done, quotient, remainder, Ovfl, div_by_zero);
endinterface

// File: rtl/seq_div_16bit.sv
// seq_div_16bit: signed restoring divider, one quotient bit per cycle, saturating on /0 and MIN/-1
module seq_div_16bit #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  seq_div_16bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = ~MAX;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   dsr;
  logic [WIDTH-1:0] dvd_raw;
  logic             sa, sb, dz, mn1;
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag, sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] q_s, r_s, q_fix, r_fix;
  always_comb begin
    a_ext = {bus.dividend[WIDTH-1], bus.dividend};
    b_ext = {bus.divisor[WIDTH-1], bus.divisor};
    a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag = b_ext[WIDTH] ? -b_ext : b_ext;
    sh    = {r[WIDTH-1:0], q[WIDTH-1]};
    diff  = {1'b0, sh} - {1'b0, dsr};
    q_s   = (sa ^ sb) ? -q : q;
    r_s   = sa ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    q_fix = dz ? (sa ? MIN : MAX) : mn1 ? MAX : q_s;
    r_fix = dz ? dvd_raw : r_s;
  end
  // q doubles as the dividend shift register: its MSB feeds the remainder while quotient bits enter at the LSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      q               <= '0;
      r               <= '0;
      dsr             <= '0;
      dvd_raw         <= '0;
      sa              <= 1'b0;
      sb              <= 1'b0;
      dz              <= 1'b0;
      mn1             <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.Ovfl        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state    <= CALC;
          bus.busy <= 1'b1;
          cnt      <= '0;
          q        <= a_mag[WIDTH-1:0];
          r        <= '0;
          dsr      <= b_mag;
          dvd_raw  <= bus.dividend;
          sa       <= bus.dividend[WIDTH-1];
          sb       <= bus.divisor[WIDTH-1];
          dz       <= bus.divisor == '0;
          mn1      <= bus.dividend == MIN && bus.divisor == '1;
        end
        CALC: begin
          r     <= diff[WIDTH+1] ? sh : diff[WIDTH:0];
          q     <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
          cnt   <= cnt + 1'b1;
          state <= cnt == CW'(WIDTH - 1) ? FIX : CALC;
        end
        FIX: begin
          bus.quotient    <= q_fix;
          bus.remainder   <= r_fix;
          bus.Ovfl        <= dz | mn1;
          bus.div_by_zero <= dz;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_16bit.sv
// tb_seq_div_16bit: directed vector table plus handshake and async-reset sequences for seq_div_16bit
module tb_seq_div_16bit;
  localparam int W = 16;
  typedef struct {
    logic [15:0] a, b, q, r;
    logic        ov, dz;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] prev_q = 16'h0000;
  vec_t vt[13];
  seq_div_16bit_if #(.WIDTH(W)) bus();
  seq_div_16bit #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Entered at a negedge; start is sampled on the next posedge (edge k).
  // lat counts negedges after edge k, so lat n shows the value registered at edge k+n-1.
  task automatic run(input vec_t v, input bit poke);
    int  lat;
    bit  busy_ok;
    bus.start    = 1'b1;
    bus.dividend = v.a;
    bus.divisor  = v.b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'(32'($urandom));
    bus.divisor  = 16'(32'($urandom));
    lat     = 1;
    busy_ok = 1'b1;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    while (!bus.done && lat < 40) begin
      bus.start = poke && lat == 3;
      if (poke && lat == 3) begin
        bus.dividend = 16'h0009;
        bus.divisor  = 16'h0002;
      end
      @(negedge clk);
      lat++;
      if (lat == 5) chk("q_stable_in_calc", {16'd0, bus.quotient}, {16'd0, prev_q});
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    chk("latency", lat, W + 2);
    chk("busy_held", {31'd0, busy_ok}, 32'd1);
    chk("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
    chk("quotient", {16'd0, bus.quotient}, {16'd0, v.q});
    chk("remainder", {16'd0, bus.remainder}, {16'd0, v.r});
    chk("flags", {30'd0, bus.Ovfl, bus.div_by_zero}, {30'd0, v.ov, v.dz});
    prev_q = v.q;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask
  initial begin
    int  spurious;
    vec_t v;
    vt[0]  = '{16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0};
    vt[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
    vt[2]  = '{16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
    vt[3]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
    vt[4]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vt[5]  = '{16'h0005, 16'h0000, 16'h7FFF, 16'h0005, 1'b1, 1'b1};
    vt[6]  = '{16'hFFFB, 16'h0000, 16'h8000, 16'hFFFB, 1'b1, 1'b1};
    vt[7]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{16'h0007, 16'h0002, 16'h0003, 16'h0001, 1'b0, 1'b0};
    vt[9]  = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[10] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0};
    vt[11] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vt[12] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    bus.start    = 1'b0;
    bus.dividend = 16'h0000;
    bus.divisor  = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_state", {12'd0, bus.busy, bus.done, bus.Ovfl, bus.div_by_zero, bus.quotient, bus.remainder}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) run(vt[i], 1'b0);
    run(vt[0], 1'b1);
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) spurious++;
    end
    chk("no_extra_op_after_poke", spurious, 0);
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_clears", {12'd0, bus.busy, bus.done, bus.Ovfl, bus.div_by_zero, bus.quotient, bus.remainder}, 32'd0);
    #9 rst_n = 1'b1;
    spurious = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done || bus.busy) spurious++;
    end
    chk("no_done_after_abort", spurious, 0);
    prev_q = 16'h0000;
    v = '{16'd1000, 16'd10, 16'h0064, 16'h0000, 1'b0, 1'b0};
    run(v, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
